// File: rtl/aes_ctrl_pkg.sv
// Shared types and defaults for the AES-128 decryption sequencer.
package aes_ctrl_pkg;

  localparam int AES_NR         = 10;
  localparam int AES_IMC_CYCLES = 4;

  // Datapath operation selects presented on op_sel.
  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LOAD = 3'd1,
    OP_ARK  = 3'd2,
    OP_ISR  = 3'd3,
    OP_ISB  = 3'd4,
    OP_IMC  = 3'd5
  } op_e;

  // Sequencer states; encodings 9..15 are unused and recover to ST_IDLE.
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_LOAD     = 4'd1,
    ST_KEYEXP   = 4'd2,
    ST_INIT_ARK = 4'd3,
    ST_ISR      = 4'd4,
    ST_ISB      = 4'd5,
    ST_ARK      = 4'd6,
    ST_IMC      = 4'd7,
    ST_DONE     = 4'd8
  } seq_state_e;

endpackage

// File: rtl/aes_decrypt_sequencer_step_counter.sv
// Round down-counter and InvMixColumns column up-counter for the sequencer.
module aes_step_counter
  import aes_ctrl_pkg::*;
#(
  parameter int NR         = AES_NR,
  parameter int IMC_CYCLES = AES_IMC_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       dec,
  input  logic       col_en,
  output logic [3:0] round,
  output logic [1:0] col_idx,
  output logic       last_col
);

  logic [3:0] round_reg;
  logic [1:0] col_reg;

  // Last column of an InvMixColumns pass.
  always_comb begin
    last_col = (col_reg == 2'(IMC_CYCLES - 1));
  end

  // Round counter loads NR-1 and saturates at 0; column counter wraps after the last column.
  always_ff @(posedge clk) begin
    if (reset) begin
      round_reg <= 4'd0;
      col_reg   <= 2'd0;
    end else begin
      if (load) begin
        round_reg <= 4'(NR - 1);
      end else if (dec && (round_reg != 4'd0)) begin
        round_reg <= round_reg - 4'd1;
      end
      if (load) begin
        col_reg <= 2'd0;
      end else if (col_en) begin
        col_reg <= last_col ? 2'd0 : col_reg + 2'd1;
      end
    end
  end

  assign round   = round_reg;
  assign col_idx = col_reg;

endmodule

// File: rtl/aes_decrypt_sequencer.sv
// Moore controller sequencing an iterative AES-128 decryption datapath.
module aes_decrypt_sequencer
  import aes_ctrl_pkg::*;
#(
  parameter int NR         = AES_NR,
  parameter int IMC_CYCLES = AES_IMC_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       done,
  output logic       busy,
  output logic       keyexp_start,
  input  logic       keyexp_done,
  output logic [2:0] op_sel,
  output logic       state_we,
  output logic [3:0] rk_idx,
  output logic [1:0] col_idx,
  output logic [3:0] round
);

  seq_state_e state_reg;
  seq_state_e state_next;

  logic       cnt_load;
  logic       cnt_dec;
  logic       cnt_col_en;
  logic [3:0] cnt_round;
  logic [1:0] cnt_col;
  logic       cnt_last_col;
  op_e        op;

  aes_step_counter #(
    .NR         (NR),
    .IMC_CYCLES (IMC_CYCLES)
  ) u_step_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .col_en   (cnt_col_en),
    .round    (cnt_round),
    .col_idx  (cnt_col),
    .last_col (cnt_last_col)
  );

  // State register; reset wins over every transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and Moore outputs; inputs only steer transitions.
  always_comb begin
    state_next   = state_reg;
    op           = OP_NOP;
    done         = 1'b0;
    busy         = 1'b1;
    keyexp_start = 1'b0;
    rk_idx       = 4'd0;
    col_idx      = 2'd0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_col_en   = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        op           = OP_LOAD;
        keyexp_start = 1'b1;
        state_next   = ST_KEYEXP;
      end
      ST_KEYEXP: begin
        // keyexp_done is only honoured here, so an early level during LOAD is harmless.
        if (keyexp_done) begin
          cnt_load   = 1'b1;
          state_next = ST_INIT_ARK;
        end
      end
      ST_INIT_ARK: begin
        op         = OP_ARK;
        rk_idx     = 4'(NR);
        state_next = ST_ISR;
      end
      ST_ISR: begin
        op         = OP_ISR;
        state_next = ST_ISB;
      end
      ST_ISB: begin
        op         = OP_ISB;
        state_next = ST_ARK;
      end
      ST_ARK: begin
        op         = OP_ARK;
        rk_idx     = cnt_round;
        state_next = (cnt_round != 4'd0) ? ST_IMC : ST_DONE;
      end
      ST_IMC: begin
        op         = OP_IMC;
        col_idx    = cnt_col;
        cnt_col_en = 1'b1;
        if (cnt_last_col) begin
          cnt_dec    = 1'b1;
          state_next = ST_ISR;
        end
      end
      ST_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        // Waiting for start to fall stops a held start from retriggering.
        if (!start) state_next = ST_IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  assign op_sel   = op;
  assign state_we = (op != OP_NOP);
  assign round    = cnt_round;

endmodule

// File: tb/tb_aes_decrypt_sequencer.sv
// Self-checking bench: expected per-cycle outputs come from a trace model built from the round schedule.
module tb_aes_decrypt_sequencer;

  localparam int NR  = 10;
  localparam int IMC = 4;

  logic       clk;
  logic       reset;
  logic       start;
  logic       done;
  logic       busy;
  logic       keyexp_start;
  logic       keyexp_done;
  logic [2:0] op_sel;
  logic       state_we;
  logic [3:0] rk_idx;
  logic [1:0] col_idx;
  logic [3:0] round;

  aes_decrypt_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .done         (done),
    .busy         (busy),
    .keyexp_start (keyexp_start),
    .keyexp_done  (keyexp_done),
    .op_sel       (op_sel),
    .state_we     (state_we),
    .rk_idx       (rk_idx),
    .col_idx      (col_idx),
    .round        (round)
  );

  typedef struct {
    string      tag;
    logic [2:0] op;
    logic       we;
    logic [3:0] rk;
    logic [1:0] col;
    logic [3:0] rnd;
    logic       dn;
    logic       bsy;
    logic       ks;
  } exp_t;

  typedef struct {
    logic [2:0] op;
    logic [3:0] rk;
    logic [1:0] col;
    logic [3:0] rnd;
  } step_t;

  exp_t  exp_q[$];
  step_t ops[$];
  logic [5:0] tr_a[$];
  logic [5:0] tr_b[$];

  int checks = 0;
  int errors = 0;
  int cycle_cnt = 0;
  int done_cyc = -1;
  int imc_seen = 0;
  int rec_sel = 0;
  logic done_q = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Expected-output constructors.
  function automatic exp_t mk(string tag, logic [2:0] op, logic [3:0] rk, logic [1:0] col,
                              logic [3:0] rnd, logic dn, logic bsy, logic ks);
    exp_t e;
    e.tag = tag; e.op = op; e.we = (op != 3'd0); e.rk = rk; e.col = col;
    e.rnd = rnd; e.dn = dn; e.bsy = bsy; e.ks = ks;
    return e;
  endfunction

  function automatic exp_t e_idle();   return mk("idle",   3'd0, 4'd0, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0); endfunction
  function automatic exp_t e_load();   return mk("load",   3'd1, 4'd0, 2'd0, 4'd0, 1'b0, 1'b1, 1'b1); endfunction
  function automatic exp_t e_keyexp(); return mk("keyexp", 3'd0, 4'd0, 2'd0, 4'd0, 1'b0, 1'b1, 1'b0); endfunction
  function automatic exp_t e_done();   return mk("done",   3'd0, 4'd0, 2'd0, 4'd0, 1'b1, 1'b0, 1'b0); endfunction
  function automatic exp_t e_step(step_t s);
    return mk("op", s.op, s.rk, s.col, s.rnd, 1'b0, 1'b1, 1'b0);
  endfunction

  function automatic step_t st(logic [2:0] op, logic [3:0] rk, logic [1:0] col, logic [3:0] rnd);
    step_t s;
    s.op = op; s.rk = rk; s.col = col; s.rnd = rnd;
    return s;
  endfunction

  // Operation schedule of one decryption: initial key add, NR-1 full rounds, final round without IMC.
  task automatic build_model();
    ops.delete();
    ops.push_back(st(3'd2, 4'(NR), 2'd0, 4'(NR - 1)));
    for (int r = NR - 1; r >= 1; r--) begin
      ops.push_back(st(3'd3, 4'd0, 2'd0, 4'(r)));
      ops.push_back(st(3'd4, 4'd0, 2'd0, 4'(r)));
      ops.push_back(st(3'd2, 4'(r), 2'd0, 4'(r)));
      for (int c = 0; c < IMC; c++) ops.push_back(st(3'd5, 4'd0, 2'(c), 4'(r)));
    end
    ops.push_back(st(3'd3, 4'd0, 2'd0, 4'd0));
    ops.push_back(st(3'd4, 4'd0, 2'd0, 4'd0));
    ops.push_back(st(3'd2, 4'd0, 2'd0, 4'd0));
  endtask

  // One clock: inputs already set are sampled at this edge; e is the state expected after it.
  task automatic cyc(input exp_t e);
    @(posedge clk);
    #1;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  // Compare DUT outputs against the model on the falling edge.
  always @(negedge clk) begin : compare
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({op_sel, state_we, rk_idx, col_idx, round, done, busy, keyexp_start} !==
          {e.op, e.we, e.rk, e.col, e.rnd, e.dn, e.bsy, e.ks}) begin
        errors++;
        $display("FAIL %s cyc=%0d got op=%0d we=%0d rk=%0d col=%0d rnd=%0d done=%0d busy=%0d ks=%0d required op=%0d we=%0d rk=%0d col=%0d rnd=%0d done=%0d busy=%0d ks=%0d",
                 e.tag, cycle_cnt, op_sel, state_we, rk_idx, col_idx, round, done, busy, keyexp_start,
                 e.op, e.we, e.rk, e.col, e.rnd, e.dn, e.bsy, e.ks);
      end
    end
    if (op_sel == 3'd5) imc_seen++;
    if (done === 1'b1 && done_q !== 1'b1) done_cyc = cycle_cnt;
    done_q = done;
    if (rec_sel == 1) tr_a.push_back({op_sel, rk_idx[2:0]} ^ {3'd0, rk_idx[3], 2'd0});
    if (rec_sel == 2) tr_b.push_back({op_sel, rk_idx[2:0]} ^ {3'd0, rk_idx[3], 2'd0});
  end

  // One decryption from IDLE; optionally aborted by reset after op index abort_at,
  // or with start dropped at op index drop_at.
  task automatic full_run(input int kwait, input bit early, input int abort_at,
                          input int drop_at, input int hold_n);
    int load_cyc;
    int ke_cyc;
    start = 1'b1;
    cyc(e_load());
    load_cyc = cycle_cnt;
    imc_seen = 0;
    keyexp_done = early;
    cyc(e_keyexp());
    for (int i = 1; i < kwait; i++) cyc(e_keyexp());
    keyexp_done = 1'b1;
    cyc(e_step(ops[0]));
    keyexp_done = 1'b0;
    ke_cyc = cycle_cnt;
    if (early) chk("early_keyexp_gap", ke_cyc - load_cyc, 2);
    for (int i = 1; i <= ops.size(); i++) begin
      if (abort_at == i - 1) begin
        reset = 1'b1;
        cyc(e_idle());
        reset = 1'b0;
        $display("run aborted by reset after op %0d", abort_at);
        return;
      end
      if (i == ops.size()) break;
      if (drop_at == i) start = 1'b0;
      cyc(e_step(ops[i]));
    end
    cyc(e_done());
    for (int i = 0; i < hold_n; i++) cyc(e_done());
    start = 1'b0;
    cyc(e_idle());
    chk("done_latency", done_cyc - ke_cyc, 1 + (NR - 1) * (3 + IMC) + 3);
    chk("imc_cycles", imc_seen, (NR - 1) * IMC);
    $display("run kwait=%0d early=%0d hold=%0d drop=%0d latency=%0d imc=%0d",
             kwait, early, hold_n, drop_at, done_cyc - ke_cyc, imc_seen);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog timeout at cycle %0d", cycle_cnt);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int abort_idx;
    int n_imc;
    int diffs;
    reset = 1'b1;
    start = 1'b0;
    keyexp_done = 1'b0;
    build_model();

    // Hand-computed pins on the model itself.
    n_imc = 0;
    foreach (ops[i]) if (ops[i].op == 3'd5) n_imc++;
    chk("model_len", ops.size(), 67);
    chk("model_imc", n_imc, 36);
    chk("model_first_rk", ops[0].rk, 10);
    chk("model_first_op", ops[0].op, 2);
    chk("model_last_op", ops[66].op, 2);
    chk("model_last_rk", ops[66].rk, 0);
    chk("model_op3_rk", ops[3].rk, 9);

    // Reset then idle.
    cyc(e_idle());
    cyc(e_idle());
    reset = 1'b0;
    for (int i = 0; i < 10; i++) cyc(e_idle());

    // Full run with done handshake held for 20 cycles.
    full_run(5, 1'b0, -1, -1, 20);

    // keyexp_done already high during LOAD.
    full_run(1, 1'b1, -1, -1, 0);

    // Reset in IMC at round 5, column 2, then restart with start held.
    abort_idx = -1;
    foreach (ops[i]) if (ops[i].op == 3'd5 && ops[i].rnd == 4'd5 && ops[i].col == 2'd2) abort_idx = i;
    chk("model_abort_idx", abort_idx, 34);
    full_run(5, 1'b0, abort_idx, -1, 0);
    full_run(5, 1'b0, -1, -1, 0);

    // start dropped mid-run: run completes, DONE lasts one cycle.
    full_run(3, 1'b0, -1, 30, 0);

    // Back-to-back runs with a one-cycle start drop; traces must match.
    rec_sel = 1;
    full_run(4, 1'b0, -1, -1, 0);
    rec_sel = 2;
    full_run(4, 1'b0, -1, -1, 0);
    @(negedge clk);
    rec_sel = 0;
    diffs = 0;
    foreach (tr_a[i]) if (i < tr_b.size() && tr_a[i] !== tr_b[i]) diffs++;
    chk("b2b_trace_len", tr_b.size(), tr_a.size());
    chk("b2b_trace_diffs", diffs, 0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_decrypt_sequencer.md
Name: aes_decrypt_sequencer

Overview:
Controller that sequences an iterative AES-128 decryption datapath: the state register, InvShiftRows, InvSubBytes, AddRoundKey and column-serial InvMixColumns units, plus the key-schedule unit.
Sits between the software I/O handshake block and the datapath. Takes a start level once the message and key registers are loaded. Drives per-cycle operation selects and round-key indices, then raises a done level until software acknowledges.

Parameters:
NR, 10, number of AES rounds; round keys are indexed 0..NR.
IMC_CYCLES, 4, cycles per InvMixColumns pass, one state column per cycle.

Ports:
clk  in  1  system clock; all logic on its rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  level from the I/O block; high means message and key are loaded and valid.
done  out  1  high in DONE; datapath result is stable and valid.
busy  out  1  high in every state except IDLE and DONE.
keyexp_start  out  1  one-cycle pulse that starts the key-schedule unit.
keyexp_done  in  1  level or pulse from the key-schedule unit; all NR+1 round keys are valid.
op_sel  out  3  datapath operation: 0 NOP, 1 LOAD msg, 2 ARK, 3 ISR, 4 ISB, 5 IMC.
state_we  out  1  write enable for the datapath state register; high whenever op_sel != NOP.
rk_idx  out  4  round-key index used by ARK; 0 when not in ARK.
col_idx  out  2  column processed by IMC; 0 when not in IMC.
round  out  4  current round counter, for debug.

Behaviour:
- Reset: on a reset edge, state goes to IDLE and the counters clear. All outputs are 0 next cycle. Reset overrides every transition, including mid-operation. The datapath state register is not cleared by this block.
- Outputs are combinational from the state and counters (Moore). No output depends combinationally on an input.
- IDLE: when start = 1, go to LOAD. Otherwise stay.
- LOAD (1 cycle): op_sel=LOAD, state_we=1, keyexp_start=1. Go to KEYEXP.
- KEYEXP: op_sel=NOP. Stay until keyexp_done=1, then go to INIT_ARK with round loaded to NR-1. keyexp_done is sampled only in this state; any assertion during LOAD is ignored.
- INIT_ARK (1 cycle): ARK with rk_idx=NR. Go to ISR.
- ISR (1 cycle): op_sel=ISR. Go to ISB.
- ISB (1 cycle): op_sel=ISB. Go to ARK.
- ARK (1 cycle): rk_idx=round.
  - If round != 0, go to IMC with the column counter at 0.
  - If round == 0, go to DONE.
- IMC (IMC_CYCLES cycles): col_idx counts 0..IMC_CYCLES-1 and state_we=1 each cycle. On the last column, decrement round and go to ISR.
- Round order: INIT_ARK, then rounds NR-1 down to 1 as ISR, ISB, ARK, IMC. The final round 0 is ISR, ISB, ARK with no IMC.
- Latency after keyexp_done is sampled: 1 + (NR-1)*(3+IMC_CYCLES) + 3 cycles in op states, then DONE. With defaults this is 67 cycles.
- DONE: op_sel=NOP, done=1. Hold until start=0, then go to IDLE. This guarantees a held start cannot retrigger a run.
- start dropping to 0 during LOAD..final ARK is ignored; the run completes and DONE then exits on the next cycle.
- round is NR-1 in INIT_ARK, then counts down. It never wraps below 0; the ARK at round 0 exits to DONE.
- col_idx wraps from IMC_CYCLES-1 to 0 only on the exit transition out of IMC.
- Illegal or unreachable state encodings go to IDLE.

Decomposition:
- Package aes_ctrl_pkg:
  - op_e enum (NOP, LOAD, ARK, ISR, ISB, IMC), 3 bits.
  - seq_state_e enum: IDLE, LOAD, KEYEXP, INIT_ARK, ISR, ISB, ARK, IMC, DONE.
  - Default constants AES_NR=10 and AES_IMC_CYCLES=4.
- One natural sub-module: aes_step_counter, holding the round down-counter and the column up-counter. Its inputs are load, dec and col_en; its outputs are round, col_idx and last_col. The FSM stays in the top module.

Test Plan:
1. Reset then idle: reset=1 for 2 cycles, then start=0 for 10 cycles -> done=0, busy=0, op_sel=0, state_we=0 throughout.
2. Full run: start=1, keyexp_done rises 5 cycles after the keyexp_start pulse.
   - First cycle after start: op_sel=1 with keyexp_start=1.
   - Then: ARK with rk_idx=10; ISR/ISB/ARK with rk_idx 9 down to 1, each followed by IMC with col_idx 0,1,2,3; final ISR/ISB/ARK with rk_idx=0.
   - done=1 exactly 67 cycles after keyexp_done is sampled. Count exactly 4*9=36 IMC cycles.
3. Done handshake: hold start=1 for 20 cycles after done -> done stays 1 and no new LOAD occurs. Drop start -> IDLE next cycle, done=0.
4. Early keyexp_done: keyexp_done=1 already during LOAD -> ignored there. Sampled in the first KEYEXP cycle, so INIT_ARK follows LOAD by exactly 2 cycles.
5. Reset mid-run: assert reset in the IMC cycle with round=5, col_idx=2 -> next cycle all outputs 0 and IDLE. With start=1, the run restarts from LOAD.
6. Back-to-back runs: two full start/done cycles with start dropped for one cycle between -> both runs produce identical op_sel/rk_idx traces.
